// File: rtl/booth4_mul.sv
// booth4_mul -- iterative radix-4 Booth multiplier for the RV64M multiply group.
//
// Retires one Booth digit (two multiplier bits) per cycle over a 132-bit
// accumulator. Operands are extended to 66 bits, so 33 digits cover the whole
// extended multiplier. The product sits in the low 128 bits of the accumulator.
//
// Optional feature: define BOOTH_MUL_EARLY_OUT_EN to finish as soon as every
// unconsumed multiplier bit (including the overlap bit) is equal. All remaining
// digits are then zero, so the outstanding shifts collapse into one step.
//
// Ports:
//   clock    in   1   rising-edge clock
//   reset_n  in   1   asynchronous active-low reset
//   start    in   1   request, sampled only in IDLE
//   op       in   2   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a        in  64   multiplicand
//   b        in  64   multiplier
//   busy     out  1   high from accept until ready drops
//   ready    out  1   one-cycle pulse, result valid
//   result   out 64   selected product half, held until the next accept
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for start; result holds the last product
// RUN   | one Booth digit per cycle
// DONE  | product complete; ready/result registered next edge

module booth4_mul (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q;
  logic [65:0]    mcand_q;
  logic [66:0]    mplier_q;   // {extended b, overlap bit}; low 3 bits are the digit
  logic [131:0]   acc_q;
  logic [5:0]     cnt_q;
  logic           busy_q, ready_q;
  logic [63:0]    result_q;

  logic           a_sgn, b_sgn;
  logic [65:0]    a_ext, b_ext;
  logic           dig_one, dig_two, dig_neg;
  logic [65:0]    pos_mult, add_val, upper_sum;
  logic [131:0]   summed, acc_step, acc_run;
  logic [66:0]    mplier_nxt;
  logic           early_hit, run_last;

  // MUL only keeps the low half, so its extension choice is free; signed
  // extension lets small negative multipliers finish early in that build.
  always_comb begin
    a_sgn = (op != 2'b11);
    b_sgn = (op == 2'b00) || (op == 2'b01);
    a_ext = {{2{a_sgn & a[63]}}, a};
    b_ext = {{2{b_sgn & b[63]}}, b};
  end

  always_comb begin
    dig_one = 1'b0;
    dig_two = 1'b0;
    dig_neg = 1'b0;
    case (mplier_q[2:0])
      3'b001, 3'b010: dig_one = 1'b1;
      3'b011:         dig_two = 1'b1;
      3'b100:         begin dig_two = 1'b1; dig_neg = 1'b1; end
      3'b101, 3'b110: begin dig_one = 1'b1; dig_neg = 1'b1; end
      default:        ;
    endcase
  end

  // Negative multiples are the inverted positive multiple plus a carry-in.
  always_comb begin
    if (dig_two)      pos_mult = {mcand_q[64:0], 1'b0};
    else if (dig_one) pos_mult = mcand_q;
    else              pos_mult = '0;
    add_val    = dig_neg ? ~pos_mult : pos_mult;
    upper_sum  = acc_q[131:66] + add_val + {65'b0, dig_neg};
    summed     = {upper_sum, acc_q[65:0]};
    acc_step   = $signed(summed) >>> 2;
    mplier_nxt = {{2{mplier_q[66]}}, mplier_q[66:2]};
  end

`ifdef BOOTH_MUL_EARLY_OUT_EN
  logic [6:0]   far_shamt;
  logic [131:0] acc_far;

  // mplier_q[66:2] are the bits still to be consumed after this digit,
  // with mplier_q[2] becoming the next overlap bit.
  always_comb begin
    early_hit = (&mplier_q[66:2]) | ~(|mplier_q[66:2]);
    far_shamt = {cnt_q, 1'b0} + 7'd2;
    acc_far   = $signed(summed) >>> far_shamt;
    acc_run   = early_hit ? acc_far : acc_step;
  end
`else
  always_comb begin
    early_hit = 1'b0;
    acc_run   = acc_step;
  end
`endif

  assign run_last = (cnt_q == 6'd0) || early_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (run_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      ready_q <= (state_q == S_DONE);
      if (state_q == S_IDLE && start) busy_q <= 1'b1;
      else if (ready_q)               busy_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q     <= op;
            mcand_q  <= a_ext;
            mplier_q <= {b_ext, 1'b0};
            acc_q    <= '0;
            cnt_q    <= 6'd32;
          end
        end
        S_RUN: begin
          acc_q    <= acc_run;
          mplier_q <= mplier_nxt;
          if (cnt_q != 6'd0) cnt_q <= cnt_q - 6'd1;
        end
        S_DONE: begin
          result_q <= (op_q == 2'b00) ? acc_q[63:0] : acc_q[127:64];
        end
        default: ;
      endcase
    end
  end

  assign busy   = busy_q;
  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_booth4_mul.sv
module tb_booth4_mul;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic        busy, ready;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

`ifdef BOOTH_MUL_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  booth4_mul dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .ready   (ready),
    .result  (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure the edge after which ready appears, and
  // check result, latency and the one-cycle ready / busy release.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] x,
                        input logic [63:0] y, input int exp_lat, input logic [63:0] exp_res);
    int lat;
    logic busy_e0;
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock);
    #1;
    start = 1'b0; a = '0; b = '0; op = 2'b00;
    busy_e0 = busy;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (ready) begin
        lat = n;
        break;
      end
    end
    chk({tag, " busy_after_E0"}, {63'b0, busy_e0}, 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, result, exp_res);
    @(posedge clock);
    #1;
    chk({tag, " ready_drop"}, {63'b0, ready}, 64'd0);
    chk({tag, " busy_drop"}, {63'b0, busy}, 64'd0);
    chk({tag, " result_hold"}, result, exp_res);
  endtask

  initial begin
    int nready, rlat;
    logic [63:0] rres;
    logic busy_ok;

    reset_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset ready", {63'b0, ready}, 64'd0);
    chk("reset busy", {63'b0, busy}, 64'd0);
    chk("reset result", result, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_op("mulhu_ff", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 34, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mul_ff",   2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, EO ? 2 : 34, 64'h1);
    run_op("mulh_min", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, EO ? 33 : 34, 64'h4000_0000_0000_0000);
    run_op("mul_min",  2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, EO ? 33 : 34, 64'h0);
    run_op("mulhsu",   2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, EO ? 3 : 34, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mulhu_m1x2", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, EO ? 3 : 34, 64'h1);

    if (!EO) begin
      // Start pulse at E10 while busy must be ignored.
      @(negedge clock);
      start = 1'b1; op = 2'b00; a = 64'd7; b = 64'd6;
      @(posedge clock);
      #1;
      start = 1'b0;
      nready = 0; rlat = 0; rres = '0; busy_ok = 1'b1;
      for (int n = 1; n <= 36; n++) begin
        @(negedge clock);
        if (n == 10) begin
          start = 1'b1; a = 64'd3; b = 64'd3;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        if (ready) begin
          nready++;
          rlat = n;
          rres = result;
        end
        if (n <= 34 && !busy) busy_ok = 1'b0;
      end
      chk("busy_start ready_count", 64'(nready), 64'd1);
      chk("busy_start latency", 64'(rlat), 64'd34);
      chk("busy_start result", rres, 64'd42);
      chk("busy_start busy_held", {63'b0, busy_ok}, 64'd1);
    end

    run_op("early_9x1", 2'b00, 64'd9, 64'd1, EO ? 2 : 34, 64'd9);

    // Reset asserted around E20 of an active MUL.
    @(negedge clock);
    start = 1'b1; op = 2'b00; a = 64'd123; b = 64'h5555_5555_5555_5555;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    chk("midrun busy_before_reset", {63'b0, busy}, 64'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrun reset ready", {63'b0, ready}, 64'd0);
    chk("midrun reset busy", {63'b0, busy}, 64'd0);
    chk("midrun reset result", result, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    nready = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (ready) nready++;
    end
    chk("midrun no_ready", 64'(nready), 64'd0);
    chk("midrun result_still_zero", result, 64'd0);

    run_op("mul_5xm3", 2'b00, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, EO ? 3 : 34, 64'hFFFF_FFFF_FFFF_FFF1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth4_mul.md
# booth4_mul

Iterative radix-4 Booth multiplier implementing the RV64M multiply group (MUL, MULH, MULHSU, MULHU). It is the companion of the SRT-4 divider in the execute stage and uses the same single-cycle `start` / one-cycle `ready` handshake, so the M-unit sequencer drives both blocks the same way. One 2-bit Booth digit is retired per cycle, and the full 128-bit product is formed internally.

## Interface
- No parameters; the datapath is fixed at XLEN = 64.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 MUL (low 64), 01 MULH (s×s high), 10 MULHSU (a signed × b unsigned, high), 11 MULHU (u×u high); sampled with `start`.
- `a`  in  64  multiplicand; sampled with `start`.
- `b`  in  64  multiplier; sampled with `start`.
- `busy`  out  1  high from the accept edge until `ready` drops.
- `ready`  out  1  one-cycle pulse: `result` valid.
- `result`  out  64  selected product half; held until the next accepted `start`.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE → RUN** on `start`=1. At this edge the block:
  - latches `op`;
  - extends `a` and `b` to 66 bits (sign-extended if treated as signed, otherwise zero-extended);
  - clears the 132-bit accumulator;
  - sets the digit counter to 32.
- **RUN, each cycle:**
  - Forms the Booth digit from multiplier bits {b[2i+1], b[2i], b[2i−1]}, with b[−1] = 0.
  - The digit is in {−2, −1, 0, +1, +2}. The block adds the matching multiple of the 66-bit multiplicand into the accumulator's upper 66 bits.
  - −2 and −1 are realised as the inverted multiple plus a carry-in.
  - The accumulator is then arithmetic-shifted right by 2.
  - The counter decrements. At 0, the block goes to DONE.
- **Digit count:** 33 digits in total, which covers the 66-bit extended multiplier.
- **DONE:** `ready`=1 for one cycle.
  - `result` = product[63:0] for MUL, otherwise product[127:64].
  - Next state is IDLE.
- **Product width:** the product is the low 128 bits of the 132-bit accumulator. All arithmetic is modulo 2^132; no overflow is flagged.
- **`start` while busy:** ignored. It is not queued.
- **Reset:** `reset_n`=0 at any time, including mid-RUN, forces IDLE. It also clears `ready`, `busy`, `result`, the accumulator and the counter to 0. No partial result is delivered.

## Timing
- Reset values: `ready`=0, `busy`=0, `result`=64'h0.
- `start` is accepted at edge E0. Digits are processed at E1…E33. `ready` and the new `result` are visible after E34.
- Latency is 34 cycles, fixed in the base build.
- `busy` rises after E0 and falls after E35, together with `ready` falling.
- A new `start` is sampled at E35 at the earliest, so throughput is one operation per 35 cycles.
- `ready` is never high for two consecutive cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **`BOOTH_MUL_EARLY_OUT_EN` defined:**
  - After each RUN iteration, if all not-yet-consumed extended multiplier bits (including the overlap bit) are equal, every remaining digit is 0. In that case the accumulator is shifted right arithmetically by 2×(remaining digits) in one step, and the block enters DONE.
  - With k digits processed (1 ≤ k ≤ 33), `ready` appears after E(k+1).
  - At least one iteration always executes.
- **Undefined:** the full 33 iterations always run and latency is fixed at 34. The early-out detection logic is absent.
- The two builds produce identical `result` values for every input.

## Test plan
- **MULHU, saturating operands:** `op`=11, a=b=64'hFFFF_FFFF_FFFF_FFFF → `result`=64'hFFFF_FFFF_FFFF_FFFE. In the base build `ready` appears after E34. Repeat with `op`=00 → `result`=64'h1.
- **MULH, most-negative operands:** `op`=01, a=b=64'h8000_0000_0000_0000 → `result`=64'h4000_0000_0000_0000. Repeat with `op`=00 → `result`=0.
- **MULHSU sign handling:** `op`=10, a=64'hFFFF_FFFF_FFFF_FFFF (−1), b=2 → `result`=64'hFFFF_FFFF_FFFF_FFFF. Same operands with `op`=11 → `result`=64'h1.
- **Start while busy:** MUL a=7, b=6. Pulse `start` at E10 with a=3, b=3 → single `ready` after E34 with `result`=42. The E10 request is ignored, and `busy` stays high throughout.
- **Reset mid-RUN:** `reset_n` low for 1 cycle at E20 of an active MUL → outputs are 0 immediately and no `ready` pulse occurs. A following `start` with MUL a=5, b=−3 → `result`=64'hFFFF_FFFF_FFFF_FFF1.
- **Early out:** with `BOOTH_MUL_EARLY_OUT_EN`, MUL a=9, b=1 → `ready` after E2, `result`=9. Without the macro, `ready` comes after E34 with the same `result`.
